reset_sequencer: RTL
====================

// Module: reset_sequencer
// PURPOSE
//  Sits directly downstream of the two-flop reset synchronizer and consumes its synchronized reset.
//  Stretches that reset, then releases N_STAGES reset domains one at a time, in index order.
//  Each stage waits for its ready/ack before the next stage is released.
//  Also provides a software re-reset path and a sticky fault output.
// PARAMETERS
//  N_STAGES        3   number of sequenced reset domains (1..8)
//  STRETCH_CYCLES  4   cycles to hold all domains in reset after rst deasserts (>=1)
//  STAGE_GAP       2   cycles between a stage ack and release of the next stage (>=0)
//  ACK_TIMEOUT     8   max cycles to wait for a stage ack (used only with RST_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1         system clock; single clock domain
//  rst          in   1         synchronous, active-high reset; driven by the reset synchronizer output
//  sw_reset_req in   1         single-cycle pulse; re-runs the full sequence
//  stage_ack    in   N_STAGES  per-domain ready; must stay high once given
//  rst_out      out  N_STAGES  per-domain reset, active-high; registered
//  seq_done     out  1         high while in RUN
//  fault        out  1         sticky fault flag
//  cur_stage    out  3         index of the stage being released or awaited
// BEHAVIOUR
//  Reset (rst=1 at a rising edge):
//   - rst_out = all ones; seq_done = 0; fault = 0; cur_stage = 0.
//   - State = HOLD; counter = 0.
//  FSM states: HOLD -> RELEASE -> WAIT_ACK -> (GAP) -> RELEASE ... -> RUN; FAULT.
//  HOLD: counter increments every cycle; at STRETCH_CYCLES-1, go to RELEASE with idx = 0.
//  RELEASE: clear rst_out[idx] on this edge; go to WAIT_ACK.
//   - Timing: rst_out[0] falls exactly STRETCH_CYCLES+1 edges after the first edge that samples rst=0.
//  WAIT_ACK: when stage_ack[idx] is sampled 1 at edge E:
//   - if idx == N_STAGES-1: go to RUN; seq_done rises at E+1.
//   - otherwise: wait STAGE_GAP cycles, idx++; rst_out[idx+1] falls at edge E+STAGE_GAP+1.
//  RUN: seq_done = 1; hold all rst_out low.
//   - If any stage_ack drops, reassert all rst_out on the next edge, clear seq_done, go to HOLD.
//  sw_reset_req in any non-reset state:
//   - rst_out = all ones on the next edge; seq_done = 0; fault = 0; counter = 0; go to HOLD.
//  Priority: rst > sw_reset_req > ack/timeout/counter events.
//  Released stages never re-enter reset individually; re-reset is always all stages at once.
//  Early acks (stage_ack[j] for j > idx) are ignored until stage j is being awaited.
//  Counter width = $clog2(max(STRETCH_CYCLES, STAGE_GAP, ACK_TIMEOUT) + 1).
//   - Counter clears on every state change; it never wraps.
//  cur_stage is zero-extended idx; it holds N_STAGES-1 in RUN and the failing idx in FAULT.
// CONFIGURATION
//  Macro RST_SEQ_TIMEOUT_EN.
//  Defined:
//   - WAIT_ACK counts cycles; if no ack within ACK_TIMEOUT cycles, go to FAULT.
//   - FAULT: rst_out = all ones; fault = 1; stays in FAULT until rst or sw_reset_req.
//   - An ack arriving on the same edge as the timeout wins (no fault).
//  Undefined:
//   - WAIT_ACK waits indefinitely; FAULT is unreachable; fault is tied to 0.
//   - ACK_TIMEOUT is ignored.
// STRUCTURE
//  Package reset_seq_pkg holds:
//   - state enum (HOLD, RELEASE, WAIT_ACK, GAP, RUN, FAULT);
//   - the counter-width function;
//   - the MAX_STAGES = 8 constant.
//  Sub-module: seq_delay_counter, a loadable down-counter with a done pulse.
//   - Shared by the HOLD, GAP and timeout paths.
//  Everything else is a single always block for the FSM plus registered outputs.
// TESTING (N_STAGES=3, STRETCH_CYCLES=4, STAGE_GAP=2, ACK_TIMEOUT=8)
//  1. Nominal sequence:
//   - rst high 3 cycles, then low; ack[0] at +7, ack[1] at +12, ack[2] at +17.
//   - rst_out[0] falls at +5; rst_out[1] falls at +10 after the ack[0] edge;
//     rst_out[2] falls at +15 after the ack[1] edge; seq_done rises one edge after ack[2].
//  2. In RUN, pulse sw_reset_req for 1 cycle:
//   - rst_out = 3'b111 next edge; seq_done = 0; the full sequence repeats with identical timing.
//  3. In RUN, drop ack[1]:
//   - rst_out = 3'b111 next edge; returns to HOLD; recovers once the acks return.
//  4. Mid-sequence reset:
//   - assert rst during WAIT_ACK for stage 1;
//   - outputs return to reset values on that edge; restart timing matches scenario 1.
//  5. Timeout (RST_SEQ_TIMEOUT_EN defined), ack[1] never arrives:
//   - fault = 1 and rst_out = 3'b111 eight cycles into WAIT_ACK; cur_stage = 1;
//   - sw_reset_req clears fault.
//   - Without the macro: no fault; still waiting after 100 cycles.
//  6. Simultaneous events:
//   - sw_reset_req on the same edge as the final ack: goes to HOLD, seq_done stays 0.
//   - ack on the timeout edge: no fault.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and sizing helpers for the reset sequencer
package reset_seq_pkg;

   localparam int MAX_STAGES = 8;

   typedef enum logic [2:0] {
      HOLD,
      RELEASE,
      WAIT_ACK,
      GAP,
      RUN,
      FAULT
   } seq_state_e;

   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a > b ? a : b;
      m = m > c ? m : c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/reset_sequencer_delay_counter.sv
// seq_delay_counter: loadable down-counter; done pulses for one cycle when an armed count reaches zero
module seq_delay_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   output logic         done
);

   logic [W-1:0] cnt;
   logic         armed;

   assign done = armed && cnt == '0;

   // a load always wins; otherwise count down to zero, fire once, then sit idle
   always_ff @(posedge clk) begin
      if (ld) begin
         cnt   <= ld_val;
         armed <= 1'b1;
      end else if (done) begin
         armed <= 1'b0;
      end else if (armed) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: stretches the synchronized reset, then releases N_STAGES domains in order with ack handshakes.
// Defining RST_SEQ_TIMEOUT_EN adds the ack timeout and the sticky FAULT state.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int N_STAGES       = 3,
   parameter int STRETCH_CYCLES = 4,
   parameter int STAGE_GAP      = 2,
   parameter int ACK_TIMEOUT    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sw_reset_req,
   input  logic [N_STAGES-1:0] stage_ack,
   output logic [N_STAGES-1:0] rst_out,
   output logic                seq_done,
   output logic                fault,
   output logic [2:0]          cur_stage
);

   localparam int W = cnt_width(STRETCH_CYCLES, STAGE_GAP, ACK_TIMEOUT);
   localparam logic [N_STAGES-1:0] ALL = '1;
   localparam logic [2:0] LAST = 3'(N_STAGES - 1);

   seq_state_e          state;
   logic [2:0]          idx;
   logic [N_STAGES-1:0] sel;
   logic                ack_cur, all_ack, is_last, drop, ld, done;
   logic [W-1:0]        ld_val;

   assign sel       = N_STAGES'(1) << idx;
   assign ack_cur   = |(stage_ack & sel);
   assign all_ack   = &stage_ack;
   assign is_last   = idx == LAST;
   assign drop      = state == RUN && !all_ack;
   assign cur_stage = idx;

   seq_delay_counter #(.W(W)) u_cnt (
      .clk    (clk),
      .ld     (ld),
      .ld_val (ld_val),
      .done   (done)
   );

   // reload the shared counter on entry to HOLD, GAP and (with timeout) WAIT_ACK
   always_comb begin
      ld     = 1'b1;
      ld_val = W'(STRETCH_CYCLES);
      if (rst || sw_reset_req || drop) ld_val = W'(STRETCH_CYCLES);
      else if (state == WAIT_ACK && ack_cur && !is_last) ld_val = W'(STAGE_GAP - 1);
`ifdef RST_SEQ_TIMEOUT_EN
      else if (state == RELEASE) ld_val = W'(ACK_TIMEOUT - 1);
`endif
      else ld = 1'b0;
   end

   // sequencing FSM with registered per-domain resets and status flags
   always_ff @(posedge clk) begin
      if (rst || sw_reset_req) begin
         state    <= HOLD;
         idx      <= '0;
         rst_out  <= ALL;
         seq_done <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
         fault    <= 1'b0;
`endif
      end else begin
         case (state)
            HOLD:
               if (done) state <= RELEASE;
            RELEASE: begin
               rst_out <= rst_out & ~sel;
               state   <= WAIT_ACK;
            end
            WAIT_ACK:
               if (ack_cur) begin
                  if (is_last) state <= RUN;
                  else if (STAGE_GAP == 0) begin
                     state <= RELEASE;
                     idx   <= idx + 3'd1;
                  end else state <= GAP;
               end
`ifdef RST_SEQ_TIMEOUT_EN
               else if (done) begin
                  state   <= FAULT;
                  rst_out <= ALL;
                  fault   <= 1'b1;
               end
`endif
            GAP:
               if (done) begin
                  state <= RELEASE;
                  idx   <= idx + 3'd1;
               end
            RUN:
               if (drop) begin
                  state    <= HOLD;
                  idx      <= '0;
                  rst_out  <= ALL;
                  seq_done <= 1'b0;
               end else seq_done <= 1'b1;
            default: ;
         endcase
      end
   end

`ifndef RST_SEQ_TIMEOUT_EN
   assign fault = 1'b0;
`endif

endmodule
